// File: rtl/adder_8_bit_pkg.sv
// Shared constants for the registered ripple-carry adder.
// Width and reset values live here so the top and the bench agree.
package adder_8_bit_pkg;
  localparam int ADDER_WIDTH = 8;
  localparam logic [ADDER_WIDTH-1:0] SUM_RST = 8'h00;
  localparam logic CO_RST = 1'b0;
endpackage

// File: rtl/adder_8_bit_full_adder.sv
// One-bit full adder.
// It is purely combinational and forms one link of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/adder_8_bit.sv
// Ripple-carry adder with the sum and the carry-out captured in a register.
// Only carry_in[0] is used as the carry; the upper carry_in bits are inert.
module adder_8_bit
  import adder_8_bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             unused_ci_hi;

  assign c[0] = carry_in[0];
  // Upper carry_in bits are deliberately dropped; they must never reach the outputs.
  assign unused_ci_hi = ^carry_in[WIDTH-1:1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= SUM_RST;
      carry_out <= CO_RST;
    end else begin
      sum       <= s;
      carry_out <= c[WIDTH];
    end
  end
endmodule

// File: tb/tb_adder_8_bit.sv
// Self-checking bench for adder_8_bit: directed corner cases, asynchronous reset
// pulses and a random compare against plain 9-bit arithmetic.
module tb_adder_8_bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] carry_in = 8'h00;
  logic [7:0] sum;
  logic       carry_out;

  int checks = 0;
  int failures = 0;
  logic [8:0] last = 9'h000;

  adder_8_bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] ci);
    int r;
    r = int'(x) + int'(y) + (ci % 2);
    return 9'(r);
  endfunction

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive operands between edges, confirm the outputs still hold, then check after the edge.
  task automatic apply(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] ci);
    @(negedge clk);
    a = x; b = y; carry_in = ci;
    #1 chk({tag, "_hold"}, {carry_out, sum}, last);
    @(posedge clk);
    #1 last = model(x, y, ci);
    chk(tag, {carry_out, sum}, last);
  endtask

  initial begin
    // Reset held with nonzero operands: outputs stay clear across edges.
    a = 8'hC7; b = 8'hE8; carry_in = 8'h00;
    #1 chk("rst_t0", {carry_out, sum}, 9'h000);
    repeat (2) @(posedge clk);
    #1 chk("rst_held", {carry_out, sum}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rel_hold", {carry_out, sum}, 9'h000);
    @(posedge clk);
    #1 chk("first_after_rel", {carry_out, sum}, 9'h1AF);
    last = 9'h1AF;

    apply("c7_p_01", 8'd199, 8'd1, 8'h00);
    chk("c7_p_01_val", {carry_out, sum}, {1'b0, 8'd200});
    apply("c7_p_e8", 8'd199, 8'd232, 8'h00);
    chk("c7_p_e8_val", {carry_out, sum}, {1'b1, 8'd175});
    apply("11_p_e8", 8'd17, 8'd232, 8'h00);
    chk("11_p_e8_val", {carry_out, sum}, {1'b0, 8'd249});
    apply("ci_01", 8'd17, 8'd232, 8'h01);
    chk("ci_01_val", {carry_out, sum}, {1'b0, 8'd250});
    apply("ci_fe", 8'd17, 8'd232, 8'hFE);
    chk("ci_fe_val", {carry_out, sum}, {1'b0, 8'd249});
    apply("wrap", 8'hFF, 8'h01, 8'h00);
    chk("wrap_val", {carry_out, sum}, 9'h100);
    apply("max", 8'hFF, 8'hFF, 8'h01);
    chk("max_val", {carry_out, sum}, 9'h1FF);
    apply("zero_ci", 8'h00, 8'h00, 8'h01);
    chk("zero_ci_val", {carry_out, sum}, 9'h001);

    // Mid-stream reset pulses between edges.
    for (int k = 0; k < 6; k++) begin
      apply("pre_rst", 8'($urandom_range(128, 255)), 8'($urandom_range(128, 255)),
            8'($urandom));
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); carry_in = 8'($urandom);
      #1 rst_n = 1'b0;
      #1 chk("async_clr", {carry_out, sum}, 9'h000);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 last = model(a, b, carry_in);
      chk("resume", {carry_out, sum}, last);
    end

    for (int i = 0; i < 1000; i++)
      apply("rand", 8'($urandom), 8'($urandom), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
